threewire_slave: RTL

//  Responder end of the three-wire serial link (tw_clock, active-low tw_cs, bidirectional tw_data).

---
 rtl/threewire_slave.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/threewire_slave.sv
// Three-wire serial link responder: oversamples tw_clock/tw_cs/tw_data in the
// in_clk domain and decodes R/W + address + data frames for a register file.
//
// Ports:
//   in_clk, in_rst          local clock, synchronous active-high reset
//   in_tw_clock, in_tw_cs   link clock and active-low chip select
//   io_tw_data              link data, driven only while returning read data
//   out_addr                address of the current/last frame
//   out_wr_data, out_wr_stb write word and its 1-cycle strobe
//   out_rd_stb, in_rd_data  read request strobe, register data one cycle later
//   out_busy                frame in progress
//   out_frame_err           1-cycle pulse when cs rises mid-frame
module threewire_slave #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 16
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_tw_clock,
    input  logic                 in_tw_cs,
    inout  wire                  io_tw_data,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [DATA_BITS-1:0] out_wr_data,
    output logic                 out_wr_stb,
    output logic                 out_rd_stb,
    input  logic [DATA_BITS-1:0] in_rd_data,
    output logic                 out_busy,
    output logic                 out_frame_err
);

    localparam int MAX_BITS = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
    localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RW,
        S_ADDR,
        S_TURN,
        S_RDATA,
        S_WDATA,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Synchronisers; all reset low so a cs held low through reset never
    // looks like a fresh frame start.
    logic [1:0] clk_sync, cs_sync, dat_sync;
    logic       clk_prev;
    logic       tw_rise, tw_fall, cs_hi, din;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            clk_sync <= '0;
            cs_sync  <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], in_tw_clock};
            cs_sync  <= {cs_sync[0], in_tw_cs};
            dat_sync <= {dat_sync[0], io_tw_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign tw_rise = clk_sync[1] & ~clk_prev;
    assign tw_fall = ~clk_sync[1] & clk_prev;
    assign cs_hi   = cs_sync[1];
    assign din     = dat_sync[1];

    // Datapath registers
    logic [CNT_W-1:0]     cnt;
    logic                 rw_q;
    logic                 armed;
    logic                 rd_pend;
    logic                 tx_loaded;
    logic [ADDR_BITS-1:0] addr_sr;
    logic [DATA_BITS-1:0] data_sr;
    logic [ADDR_BITS-1:0] addr_word;
    logic [DATA_BITS-1:0] data_word;

    assign addr_word = {addr_sr[ADDR_BITS-2:0], din};
    assign data_word = {data_sr[DATA_BITS-2:0], din};

    // FSM controls
    logic abort;
    logic get_rw;
    logic sh_addr, ld_addr;
    logic rd_req;
    logic sh_w, ld_w;
    logic sh_tx;
    logic ld_dcnt;
    logic dec;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        get_rw  = 1'b0;
        sh_addr = 1'b0;
        ld_addr = 1'b0;
        rd_req  = 1'b0;
        sh_w    = 1'b0;
        ld_w    = 1'b0;
        sh_tx   = 1'b0;
        ld_dcnt = 1'b0;
        dec     = 1'b0;

        // cs rising mid-frame beats any coincident link clock edge
        if (cs_hi && state_q != S_IDLE && state_q != S_DONE) begin
            abort   = 1'b1;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (armed && !cs_hi) state_d = S_RW;
                end
                S_RW: begin
                    if (tw_rise) begin
                        get_rw  = 1'b1;
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (tw_rise) begin
                        sh_addr = 1'b1;
                        if (cnt == '0) begin
                            ld_addr = 1'b1;
                            if (rw_q) begin
                                ld_dcnt = 1'b1;
                                state_d = S_WDATA;
                            end else begin
                                rd_req  = 1'b1;
                                state_d = S_TURN;
                            end
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                S_TURN: begin
                    if (tx_loaded && tw_fall) begin
                        ld_dcnt = 1'b1;
                        state_d = S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (tw_fall) begin
                        if (cnt != '0) begin
                            sh_tx = 1'b1;
                            dec   = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_WDATA: begin
                    if (tw_rise) begin
                        sh_w = 1'b1;
                        if (cnt == '0) begin
                            ld_w    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (cs_hi) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cnt           <= '0;
            rw_q          <= 1'b0;
            armed         <= 1'b0;
            rd_pend       <= 1'b0;
            tx_loaded     <= 1'b0;
            addr_sr       <= '0;
            data_sr       <= '0;
            out_addr      <= '0;
            out_wr_data   <= '0;
            out_wr_stb    <= 1'b0;
            out_rd_stb    <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            out_wr_stb    <= ld_w;
            out_rd_stb    <= rd_req;
            out_frame_err <= abort;
            rd_pend       <= out_rd_stb;

            if (cs_hi) armed <= 1'b1;

            if (get_rw) begin
                rw_q <= din;
                cnt  <= ADDR_LAST;
            end
            if (ld_dcnt) cnt <= DATA_LAST;
            if (dec)     cnt <= cnt - 1'b1;

            if (sh_addr) addr_sr  <= addr_word;
            if (ld_addr) out_addr <= addr_word;

            if (sh_w) data_sr     <= data_word;
            if (ld_w) out_wr_data <= data_word;

            // register file answers one cycle after the read strobe
            if (rd_pend && state_q == S_TURN) begin
                data_sr   <= in_rd_data;
                tx_loaded <= 1'b1;
            end
            if (sh_tx) data_sr <= {data_sr[DATA_BITS-2:0], 1'b0};
            if (state_q == S_IDLE) tx_loaded <= 1'b0;
        end
    end

    // Drop the driver in the same cycle cs is seen high
    logic oe;
    assign oe         = (state_q == S_RDATA) && !cs_hi;
    assign io_tw_data = oe ? data_sr[DATA_BITS-1] : 1'bz;
    assign out_busy   = (state_q != S_IDLE);

endmodule
